// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, state encoding and NOP constant
// for the instruction-memory loader and its RAM.
package imem_loader_pkg;

  localparam int IMEM_ADDR_WIDTH = 8;
  localparam int IMEM_DEPTH      = 256;
  localparam int INSTR_WIDTH     = 32;

  localparam logic [31:0] NOP_INSTR = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_loader_ram.sv
// imem_ram: DEPTH x DW array, sync write port (i_we/i_waddr/i_wdata),
// sync read port (i_re/i_raddr -> o_rdata) with sync clear (i_rclr).
module imem_ram
  import imem_loader_pkg::*;
#(
  parameter int AW    = IMEM_ADDR_WIDTH,
  parameter int DW    = INSTR_WIDTH,
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic          i_rclr,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Array has no reset: contents survive resetn.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     r_rdata <= DW'(NOP_INSTR);
    else if (i_rclr) r_rdata <= DW'(NOP_INSTR);
    else if (i_re)   r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program (in_valid/in_ready/in_data) into the
// instruction RAM, holds the CPU via cpu_hold, then serves fetch_addr.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = INSTR_WIDTH,
  parameter int DEPTH      = IMEM_DEPTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  cpu_hold,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_instr
);

  localparam logic [ADDR_WIDTH:0] LEN_MAX =
    (ADDR_WIDTH+1)'(DEPTH);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_words;
  logic [ADDR_WIDTH:0]   r_len;
  logic                  r_done;

  logic w_len_ok;
  logic w_start;
  logic w_xfer;
  logic w_last;
  logic w_run;

  assign w_len_ok = (load_len != '0) && (load_len <= LEN_MAX);
  assign w_xfer   = in_valid && in_ready;
  assign w_last   = (r_words == r_len - 1'b1);
  assign w_run    = (r_state == ST_RUN);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        if (load_start && w_len_ok) begin
          w_next  = ST_LOAD;
          w_start = 1'b1;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_next = ST_RUN;
      end
      ST_RUN: begin
        cpu_hold = 1'b0;
        if (load_start && w_len_ok) begin
          w_next  = ST_LOAD;
          w_start = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Start wins over transfer; in IDLE/RUN in_ready is low anyway.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_words  <= '0;
      r_len    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last;
      if (w_start) begin
        r_len    <= load_len;
        r_wr_ptr <= '0;
        r_words  <= '0;
      end else if (w_xfer) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_words  <= r_words + 1'b1;
      end
    end
  end

  assign load_done    = r_done;
  assign words_loaded = r_words;

  // Read register loads in RUN (including the start cycle of a
  // reload) and is cleared to NOP on any edge outside RUN.
  imem_ram #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (clock),
    .resetn  (resetn),
    .i_we    (w_xfer),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_re    (w_run),
    .i_rclr  (!w_run),
    .i_raddr (fetch_addr),
    .o_rdata (fetch_instr)
  );

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random + directed stimulus against a behavioural
// model of the loader; every-cycle compare plus literal pins.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        load_start = 1'b0;
  logic [8:0]  load_len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        load_done;
  logic [8:0]  words_loaded;
  logic        cpu_hold;
  logic [7:0]  fetch_addr = '0;
  logic [31:0] fetch_instr;

  int checks = 0;
  int failures = 0;
  bit arm = 1'b0;

  imem_loader dut (
    .clock        (clock),
    .resetn       (resetn),
    .load_start   (load_start),
    .load_len     (load_len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .load_done    (load_done),
    .words_loaded (words_loaded),
    .cpu_hold     (cpu_hold),
    .fetch_addr   (fetch_addr),
    .fetch_instr  (fetch_instr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: loading / running flags, word count,
  // shadow memory with known-flags.
  bit          m_load, m_run, m_done, m_fok;
  int          m_cnt, m_len;
  logic [31:0] m_fetch;
  logic [31:0] m_mem [256];
  bit          m_known [256];

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_load  <= 1'b0;
      m_run   <= 1'b0;
      m_done  <= 1'b0;
      m_cnt   <= 0;
      m_fetch <= '0;
      m_fok   <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_run) begin
        m_fetch <= m_mem[fetch_addr];
        m_fok   <= m_known[fetch_addr];
      end else begin
        m_fetch <= '0;
        m_fok   <= 1'b1;
      end
      if (m_load) begin
        if (in_valid) begin
          m_mem[m_cnt]   <= in_data;
          m_known[m_cnt] <= 1'b1;
          m_cnt          <= m_cnt + 1;
          if (m_cnt + 1 == m_len) begin
            m_load <= 1'b0;
            m_run  <= 1'b1;
            m_done <= 1'b1;
          end
        end
      end else if (load_start && int'(load_len) >= 1
                   && int'(load_len) <= 256) begin
        m_load <= 1'b1;
        m_run  <= 1'b0;
        m_len  <= int'(load_len);
        m_cnt  <= 0;
      end
    end
  end

  always @(negedge clock) begin
    if (arm) begin
      chk("cpu_hold", 32'(cpu_hold), 32'(!m_run));
      chk("in_ready", 32'(in_ready), 32'(m_load));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("words_loaded", 32'(words_loaded), 32'(m_cnt));
      if (m_fok) chk("fetch_instr", fetch_instr, m_fetch);
    end
  end

  logic [31:0] wq [256];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input int len);
    load_start = 1'b1;
    load_len   = 9'(len);
    in_valid   = 1'b1;
    in_data    = 32'hBAD0BAD0;
    tick();
    load_start = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic send(input int n, input bit gaps);
    int  idx = 0;
    int  guard = 0;
    bit  rdy;
    while (idx < n && guard < 4000) begin
      in_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data    = wq[idx];
      load_start = gaps && ($urandom_range(0, 7) == 0);
      load_len   = 9'($urandom_range(1, 256));
      rdy = in_ready;
      tick();
      if (in_valid && rdy) idx++;
      guard++;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    chk("send_done", 32'(idx), 32'(n));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  initial begin
    int pat [5] = '{1, 0, 0, 1, 1};
    int steps [5] = '{1, 1, 1, 2, 3};
    #1;
    resetn = 1'b0;
    #1;
    arm = 1'b1;
    repeat (3) tick();
    resetn = 1'b1;
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    repeat (10) tick();
    chk("idle_hold", 32'(cpu_hold), 32'd1);

    // Basic load, in_valid also high in the start cycle.
    wq[0] = 32'h11111111; wq[1] = 32'h22222222;
    wq[2] = 32'h33333333; wq[3] = 32'h44444444;
    start(4);
    chk("start_no_word", 32'(words_loaded), 32'd0);
    send(4, 1'b0);
    chk("basic_done", 32'(load_done), 32'd1);
    chk("basic_hold", 32'(cpu_hold), 32'd0);
    fetch_addr = 8'd2;
    tick();
    chk("basic_done_low", 32'(load_done), 32'd0);
    chk("basic_fetch2", fetch_instr, 32'h33333333);

    // Backpressure: in_valid 1,0,0,1,1.
    start(3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(pat[i]);
      in_data  = 32'hA0000000 + 32'(i);
      tick();
      chk("bp_words", 32'(words_loaded), 32'(steps[i]));
    end
    in_valid = 1'b1;
    chk("bp_ready_after", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_words_hold", 32'(words_loaded), 32'd3);

    // Bounds.
    do_reset();
    start(0);
    chk("len0_hold", 32'(cpu_hold), 32'd1);
    chk("len0_ready", 32'(in_ready), 32'd0);
    start(257);
    chk("len257_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 256; i++) wq[i] = 32'(i);
    start(256);
    send(256, 1'b1);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_words", 32'(words_loaded), 32'd256);
    fetch_addr = 8'd255;
    tick();
    chk("full_fetch255", fetch_instr, 32'd255);
    fetch_addr = 8'd0;
    tick();
    chk("full_fetch0", fetch_instr, 32'd0);

    // Reload from RUN; fetch issued in start cycle completes.
    fetch_addr = 8'd7;
    start(1);
    chk("reload_hold", 32'(cpu_hold), 32'd1);
    chk("reload_last_fetch", fetch_instr, 32'd7);
    wq[0] = 32'hDEADBEEF;
    send(1, 1'b0);
    chk("reload_nop", fetch_instr, 32'd0);
    fetch_addr = 8'd0;
    tick();
    chk("reload_fetch0", fetch_instr, 32'hDEADBEEF);
    fetch_addr = 8'd1;
    tick();
    chk("reload_fetch1", fetch_instr, 32'd1);

    // Reset mid-load.
    for (int i = 0; i < 5; i++) wq[i] = $urandom;
    start(5);
    send(2, 1'b0);
    resetn = 1'b0;
    #1;
    chk("midrst_hold", 32'(cpu_hold), 32'd1);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) wq[i] = $urandom;
    start(5);
    send(5, 1'b1);
    fetch_addr = 8'd4;
    tick();
    chk("midrst_fetch4", fetch_instr, wq[4]);

    // Random reloads and fetches.
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) wq[i] = $urandom;
      start(n);
      send(n, 1'b1);
      for (int c = 0; c < 20; c++) begin
        fetch_addr = 8'($urandom);
        load_start = ($urandom_range(0, 5) == 0);
        load_len   = ($urandom_range(0, 1) == 0) ? 9'd0 : 9'd257;
        tick();
      end
      load_start = 1'b0;
    end

    arm = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Loadable instruction memory and the write-side counterpart of the pipeline's instruction fetch.
- Accepts a program as a valid/ready stream of 32-bit words and writes the words into a 256x32 instruction RAM.
- Holds the pipeline, via cpu_hold, until the load completes.
- After the load, serves the IF-stage fetch port with 1-cycle synchronous read latency, matching the existing PC/fetch timing.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction RAM.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 256, number of words; equals 2**ADDR_WIDTH.

Ports:
- clock  in  1  rising-edge clock shared with pipeline.
- resetn  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle request to begin a load.
- load_len  in  ADDR_WIDTH+1  number of words to load; valid range 1..DEPTH; sampled with load_start.
- in_valid  in  1  in_data holds a word.
- in_data  in  DATA_WIDTH  program word.
- in_ready  out  1  loader accepts a word this cycle.
- load_done  out  1  one-cycle pulse when the last word has been written.
- words_loaded  out  ADDR_WIDTH+1  words written in the current or most recent load.
- cpu_hold  out  1  high while the pipeline must not fetch or advance.
- fetch_addr  in  ADDR_WIDTH  word address from PC (pc_out[7:0]).
- fetch_instr  out  DATA_WIDTH  instruction at fetch_addr, registered.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; wr_ptr=0; words_loaded=0; len_q=0.
  - load_done=0; fetch_instr=0; in_ready=0; cpu_hold=1.
  - RAM contents are not cleared.
- State machine, registered, states IDLE, LOAD, RUN:
  - IDLE: cpu_hold=1, in_ready=0.
    - load_start=1 with 1<=load_len<=DEPTH -> LOAD; len_q<=load_len, wr_ptr<=0, words_loaded<=0.
    - load_len=0 or >DEPTH: request ignored; stay IDLE.
  - LOAD: in_ready=1 (combinational from state), cpu_hold=1.
    - Transfer occurs on in_valid&&in_ready: mem[wr_ptr]<=in_data, wr_ptr<=wr_ptr+1, words_loaded<=words_loaded+1.
    - Transfer with words_loaded==len_q-1 (last word) -> RUN; load_done=1 for exactly the next cycle; in_ready deasserts in that cycle.
    - in_valid low: no state change; no timeout.
    - load_start during LOAD is ignored.
  - RUN: cpu_hold=0, in_ready=0.
    - Every edge: fetch_instr<=mem[fetch_addr] (1-cycle latency).
    - load_start with valid len -> LOAD, same latch rules; cpu_hold rises the following cycle.
    - The fetch issued in the load_start cycle still completes.
- cpu_hold = (state != RUN), derived from the registered state. Never glitches high in RUN.
- fetch_instr:
  - Updates only in RUN.
  - On transition into LOAD or IDLE, cleared to 0 (NOP) on the next edge.
  - Holds 0 until RUN.
- wr_ptr is ADDR_WIDTH bits.
  - For len=DEPTH, the last write is at address DEPTH-1. Never wraps within a load.
  - Reset to 0 at each load start.
- words_loaded saturates at len_q; it never exceeds len_q since in_ready drops after the last word.
- No read/write collision: reads only in RUN, writes only in LOAD.
- Reset mid-load:
  - Immediately IDLE with cpu_hold=1.
  - Words already written remain in RAM.
  - A new load_start is required.
- Simultaneous load_start and in_valid in IDLE: only the start is taken; first word accepted no earlier than the next cycle.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2.
  - IMEM_ADDR_WIDTH=8, IMEM_DEPTH=256, INSTR_WIDTH=32.
  - NOP_INSTR=32'd0.
- One sub-module, imem_ram: DEPTH x DATA_WIDTH, one synchronous write port, one synchronous read port with read-enable and synchronous clear of the read register.
- FSM, counters and handshake stay in imem_loader.

Test Plan:
- Reset then idle: resetn low 3 cycles -> cpu_hold=1, in_ready=0, fetch_instr=0, load_done=0; no change for 10 cycles without load_start.
- Basic load:
  - Stimulus: load_start, load_len=4, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with in_valid always high.
  - Response: 4 transfers; load_done pulses once the cycle after the 4th; cpu_hold falls that same cycle.
  - Then fetch_addr=2 -> fetch_instr=0x33333333 one cycle later.
- Backpressure and gaps: in_valid toggled 1,0,0,1,1 with load_len=3 -> words_loaded steps 1,1,1,2,3; exactly 3 writes; extra in_valid after done gets in_ready=0.
- Bounds:
  - load_len=0 and load_len=257 -> stay IDLE.
  - load_len=256 with addresses as data -> load_done after 256 transfers; fetch_addr=255 returns 255; fetch_addr=0 returns 0.
- Reload from RUN: load_start with load_len=1, word 0xDEADBEEF -> cpu_hold high next cycle and fetch_instr=0 while loading; after load_done, fetch_addr=0 returns 0xDEADBEEF and fetch_addr=1 still returns old contents.
- Reset mid-load: resetn pulsed low after 2 of 5 words -> IDLE, cpu_hold=1, in_ready=0; a new 5-word load completes normally.
